// File: rtl/rf_wport_arbiter_pkg.sv
// Shared core types: bypass bus, writeback request record and arbiter defaults.
package core;

  localparam int CORE_XLEN             = 32;
  localparam int STARVE_LIMIT_DEFAULT = 3;

  typedef struct packed {
    logic [4:0]           rd_addr;
    logic [CORE_XLEN-1:0] rd;
  } bypass_bus_t;

  typedef struct packed {
    logic                 valid;
    logic [4:0]           rd_addr;
    logic [CORE_XLEN-1:0] rd;
  } wb_req_t;

endpackage

// File: rtl/rf_wport_arbiter_fifo.sv
// Small circular buffer of pending multi-cycle results; exposes every slot's
// destination and liveness so the arbiter can flag read-after-write hazards.
module wb_result_fifo
  import core::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = CORE_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  wb_req_t                  push_data_i,
  input  logic                     pop_i,
  output wb_req_t                  head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DEPTH-1:0]         ent_valid_o,
  output logic [DEPTH-1:0][4:0]    ent_addr_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      mem_addr_q [DEPTH];
  logic [XLEN-1:0] mem_rd_q   [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (pop_i && !push_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; liveness comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_addr_q[wr_ptr_q] <= push_data_i.rd_addr;
      mem_rd_q[wr_ptr_q]   <= push_data_i.rd;
    end
  end

  always_comb begin
    logic [PW-1:0] offset;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PW'(i) - rd_ptr_q;
      ent_valid_o[i] = ({1'b0, offset} < count_q);
      ent_addr_o[i]  = mem_addr_q[i];
    end
  end

  assign head_o.valid   = (count_q != '0);
  assign head_o.rd_addr = mem_addr_q[rd_ptr_q];
  assign head_o.rd      = mem_rd_q[rd_ptr_q];
  assign count_o        = count_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the single register-file write port between the in-order writeback
// stream and buffered multi-cycle results, with starvation relief and hazards.
module rf_wport_arbiter
  import core::*;
#(
  parameter int XLEN         = CORE_XLEN,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_valid_i,
  input  logic [4:0]      pipe_rd_addr_i,
  input  logic [XLEN-1:0] pipe_rd_i,
  input  logic            mc_valid_i,
  output logic            mc_ready_o,
  input  logic [4:0]      mc_rd_addr_i,
  input  logic [XLEN-1:0] mc_rd_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output bypass_bus_t     rf_bp_o,
  output logic            stall_o,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic            hazard_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  wb_req_t              head;
  wb_req_t              push_data;
  logic [CW-1:0]        count;
  logic [DEPTH-1:0]     ent_valid;
  logic [DEPTH-1:0][4:0] ent_addr;

  logic [SW-1:0] starve_q, starve_d;
  logic          pipe_req;
  logic          fifo_empty;
  logic          starved;
  logic          push;
  logic          pop;

  assign pipe_req   = pipe_valid_i && (pipe_rd_addr_i != 5'd0);
  assign fifo_empty = !head.valid;
  assign starved    = (starve_q == SW'(STARVE_LIMIT));
  assign mc_ready_o = (count < CW'(DEPTH));
  // Results to x0 complete the handshake but never occupy a slot.
  assign push       = mc_valid_i && mc_ready_o && (mc_rd_addr_i != 5'd0);

  assign push_data.valid   = 1'b1;
  assign push_data.rd_addr = mc_rd_addr_i;
  assign push_data.rd      = mc_rd_i;

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .ent_valid_o (ent_valid),
    .ent_addr_o  (ent_addr)
  );

  // Pipeline keeps priority until it has beaten a waiting head STARVE_LIMIT times.
  always_comb begin
    rf_we_o    = pipe_req;
    rf_waddr_o = pipe_rd_addr_i;
    rf_wdata_o = pipe_rd_i;
    pop        = 1'b0;
    stall_o    = 1'b0;
    if (!fifo_empty && (!pipe_req || starved)) begin
      pop        = 1'b1;
      stall_o    = pipe_req;
      rf_we_o    = 1'b1;
      rf_waddr_o = head.rd_addr;
      rf_wdata_o = head.rd;
    end
  end

  assign rf_bp_o.rd_addr = rf_we_o ? rf_waddr_o : 5'd0;
  assign rf_bp_o.rd      = rf_wdata_o;

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty)
      starve_d = '0;
    else if (pipe_req && !starved)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] &&
          (((rs1_addr_i != 5'd0) && (ent_addr[i] == rs1_addr_i)) ||
           ((rs2_addr_i != 5'd0) && (ent_addr[i] == rs2_addr_i))))
        hazard_o = 1'b1;
    end
  end

endmodule
